// File: rtl/pe_drv_pkg.sv
// Shared definitions for the PE stream driver: FSM state encoding,
// cluster geometry and lane pack/unpack helpers.
package pe_drv_pkg;

    localparam int LANES    = 16;
    localparam int DATA_W   = 8;
    localparam int TREE_LAT = 4;
    localparam int LANE_W   = LANES * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUT
    } drv_state_t;

    // Extract one lane element from a packed lane word (lane 0 in the LSBs).
    function automatic logic [DATA_W-1:0] lane_get(input logic [LANE_W-1:0] word,
                                                   input int lane);
        return word[lane*DATA_W +: DATA_W];
    endfunction

    // Replace one lane element inside a packed lane word.
    function automatic logic [LANE_W-1:0] lane_put(input logic [LANE_W-1:0] word,
                                                   input int lane,
                                                   input logic [DATA_W-1:0] value);
        logic [LANE_W-1:0] result;
        result = word;
        result[lane*DATA_W +: DATA_W] = value;
        return result;
    endfunction

endpackage

// File: rtl/pe_drv_delay_line.sv
// Fixed-depth 1-bit shift register used to align the first/last chunk
// flags with the PE adder tree and accumulator.
module pe_drv_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] taps;

    // Shift the flag one stage per cycle; reset flushes any flag in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taps <= '0;
        end else begin
            taps <= {taps[DEPTH-2:0], din};
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/pe_stream_driver.sv
// Job-level initiator for the 16-lane PE cluster: streams IFM/weight
// chunks from the buffers onto the PE lanes, frames the accumulation with
// pe_reset/pe_finish and hands the OFM back over a valid/ready handshake.
// Optional build macro DRV_PERF_CNT_EN adds a 32-bit busy-cycle counter
// output perf_cycles.
module pe_stream_driver
    import pe_drv_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_chunks,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic [ADDR_W-1:0] wt_base,
    output logic              busy,
    output logic              done,
    output logic              ifm_rd_en,
    output logic [ADDR_W-1:0] ifm_rd_addr,
    input  logic [LANE_W-1:0] ifm_rd_data,
    output logic              wt_rd_en,
    output logic [ADDR_W-1:0] wt_rd_addr,
    input  logic [LANE_W-1:0] wt_rd_data,
    output logic [LANE_W-1:0] pe_ifm,
    output logic [LANE_W-1:0] pe_wt,
    output logic              pe_reset,
    output logic              pe_finish,
    input  logic [DATA_W-1:0] pe_ofm,
    input  logic              pe_valid,
    output logic [DATA_W-1:0] ofm_data,
    output logic              ofm_valid,
    input  logic              ofm_ready
`ifdef DRV_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    drv_state_t        state;
    drv_state_t        state_next;
    logic [CNT_W-1:0]  n_reg;
    logic [CNT_W-1:0]  idx;
    logic [ADDR_W-1:0] ifm_base_reg;
    logic [ADDR_W-1:0] wt_base_reg;
    logic              start_ok;
    logic              fetch;
    logic              last_rd;
    logic              lane_vld;
    logic              first_q;
    logic              last_q;

    assign start_ok = (state == IDLE) && start;
    assign fetch    = (state == FETCH);
    assign last_rd  = fetch && (idx == (n_reg - CNT_W'(1)));

    // Next-state selection; a zero-chunk job skips straight to the result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (num_chunks == '0) ? OUT : FETCH;
            FETCH:   if (last_rd) state_next = DRAIN;
            DRAIN:   if (pe_valid) state_next = OUT;
            OUT:     if (ofm_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Job parameters, fetch index and captured result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_reg        <= '0;
            idx          <= '0;
            ifm_base_reg <= '0;
            wt_base_reg  <= '0;
            ofm_data     <= '0;
        end else begin
            if (start_ok) begin
                n_reg        <= num_chunks;
                ifm_base_reg <= ifm_base;
                wt_base_reg  <= wt_base;
                idx          <= '0;
                if (num_chunks == '0) ofm_data <= '0;
            end else if (fetch) begin
                idx <= idx + CNT_W'(1);
            end
            if ((state == DRAIN) && pe_valid) ofm_data <= pe_ofm;
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == OUT) && ofm_ready;
    assign ofm_valid   = (state == OUT);
    assign ifm_rd_en   = fetch;
    assign wt_rd_en    = fetch;
    assign ifm_rd_addr = fetch ? (ifm_base_reg + ADDR_W'(idx)) : '0;
    assign wt_rd_addr  = fetch ? (wt_base_reg + ADDR_W'(idx)) : '0;

    // Lane-valid and chunk flags follow the 1-cycle buffer read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_vld <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            lane_vld <= fetch;
            first_q  <= fetch && (idx == '0);
            last_q   <= last_rd;
        end
    end

    // Idle lanes carry zeros so the PE accumulator stays put between jobs.
    always_comb begin
        pe_ifm = lane_vld ? ifm_rd_data : '0;
        pe_wt  = lane_vld ? wt_rd_data : '0;
    end

    pe_drv_delay_line #(.DEPTH(TREE_LAT)) u_first_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (first_q),
        .dout    (pe_reset)
    );

    pe_drv_delay_line #(.DEPTH(TREE_LAT + 1)) u_last_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (last_q),
        .dout    (pe_finish)
    );

`ifdef DRV_PERF_CNT_EN
    // Busy-cycle counter: cleared on each accepted start, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
